// File: rtl/approx_mult_err_engine.sv
// Error-characterisation engine for an external approximate multiplier.
// Issues operand pairs, pairs each dut_y with an exact product and accumulates error metrics.
module approx_mult_err_engine #(
    parameter int              N         = 16,
    parameter int              DUT_LAT   = 0,
    parameter logic [2*N-1:0]  LFSR_TAPS = 32'h80200003
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               mode,
    input  logic [2*N-1:0]     seed,
    input  logic [2*N:0]       num_samples,
    output logic [N-1:0]       dut_a,
    output logic [N-1:0]       dut_b,
    input  logic [2*N-1:0]     dut_y,
    output logic               busy,
    output logic               done,
    output logic [2*N:0]       vec_count,
    output logic [2*N:0]       err_count,
    output logic [4*N-1:0]     sae,
    output logic [2*N-1:0]     max_ed
);

    localparam int PW = 2 * N;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic            mode_r;
    logic [PW:0]     rem_r;
    logic [PW-1:0]   lfsr_r;
    logic [PW-1:0]   lfsr_nxt;
    logic [PW-1:0]   seed_eff;
    logic            vld_p0;
    logic            launch, issue_next, stop_issue, flush, last_vec;

    logic [N-1:0]    a_al, b_al;
    logic            vld_al, dly_busy;

    logic [PW-1:0]   y_p1, exact_p1;
    logic            vld_p1;
    logic [PW-1:0]   ed_p2;
    logic            vld_p2;

    function automatic logic [PW-1:0] lfsr_step(input logic [PW-1:0] v);
        lfsr_step = v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    function automatic logic [PW-1:0] abs_diff(input logic [PW-1:0] x, input logic [PW-1:0] y);
        abs_diff = (x >= y) ? (x - y) : (y - x);
    endfunction

    assign seed_eff = (seed == '0) ? '1 : seed;
    assign lfsr_nxt = lfsr_step(lfsr_r);
    assign last_vec = mode_r ? (rem_r == '0) : (&{dut_a, dut_b});
    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        launch     = 1'b0;
        issue_next = 1'b0;
        stop_issue = 1'b0;
        flush      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start && !abort) begin
                    launch  = 1'b1;
                    state_d = (mode && (num_samples == '0)) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (last_vec) begin
                    stop_issue = 1'b1;
                    state_d    = DRAIN;
                end else begin
                    issue_next = 1'b1;
                end
            end
            DRAIN: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (vld_p2 && !vld_p1 && !dly_busy) begin
                    // the vector in stage E is the last one; it lands on the metrics this edge
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand source: registered dut_a/dut_b, valid during RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            dut_a  <= '0;
            dut_b  <= '0;
            lfsr_r <= '1;
            mode_r <= 1'b0;
            rem_r  <= '0;
            vld_p0 <= 1'b0;
        end else if (launch) begin
            mode_r <= mode;
            lfsr_r <= seed_eff;
            rem_r  <= num_samples - (PW+1)'(1);
            if (mode) begin
                {dut_a, dut_b} <= seed_eff;
                vld_p0         <= (num_samples != '0);
            end else begin
                {dut_a, dut_b} <= '0;
                vld_p0         <= 1'b1;
            end
        end else if (issue_next) begin
            if (mode_r) begin
                lfsr_r         <= lfsr_nxt;
                {dut_a, dut_b} <= lfsr_nxt;
                rem_r          <= rem_r - (PW+1)'(1);
            end else begin
                {dut_a, dut_b} <= {dut_a, dut_b} + PW'(1);
            end
        end else if (stop_issue || flush) begin
            vld_p0 <= 1'b0;
        end
    end

    // Operand delay line matching the DUT latency
    if (DUT_LAT == 0) begin : g_nolat
        assign a_al     = dut_a;
        assign b_al     = dut_b;
        assign vld_al   = vld_p0;
        assign dly_busy = 1'b0;
    end else begin : g_lat
        logic [N-1:0]       a_sr [DUT_LAT];
        logic [N-1:0]       b_sr [DUT_LAT];
        logic [DUT_LAT-1:0] vld_sr;

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                vld_sr <= '0;
            end else begin
                vld_sr[0] <= vld_p0;
                for (int i = 1; i < DUT_LAT; i++) vld_sr[i] <= vld_sr[i-1];
            end
        end

        always_ff @(posedge clk) begin
            a_sr[0] <= dut_a;
            b_sr[0] <= dut_b;
            for (int i = 1; i < DUT_LAT; i++) begin
                a_sr[i] <= a_sr[i-1];
                b_sr[i] <= b_sr[i-1];
            end
        end

        assign a_al     = a_sr[DUT_LAT-1];
        assign b_al     = b_sr[DUT_LAT-1];
        assign vld_al   = vld_sr[DUT_LAT-1];
        assign dly_busy = |vld_sr;
    end

    // Stage C: capture DUT product and exact product
    always_ff @(posedge clk) begin
        if (rst || flush) vld_p1 <= 1'b0;
        else              vld_p1 <= vld_al;
    end

    always_ff @(posedge clk) begin
        y_p1     <= dut_y;
        exact_p1 <= PW'(a_al) * PW'(b_al);
    end

    // Stage E: absolute error distance
    always_ff @(posedge clk) begin
        if (rst || flush) vld_p2 <= 1'b0;
        else              vld_p2 <= vld_p1;
    end

    always_ff @(posedge clk) begin
        ed_p2 <= abs_diff(y_p1, exact_p1);
    end

    // Stage A: metric accumulation
    always_ff @(posedge clk) begin
        if (rst || launch) begin
            vec_count <= '0;
            err_count <= '0;
            sae       <= '0;
            max_ed    <= '0;
        end else if (vld_p2 && !flush) begin
            vec_count <= vec_count + (PW+1)'(1);
            err_count <= err_count + (PW+1)'(ed_p2 != '0);
            sae       <= sae + (4*N)'(ed_p2);
            if (ed_p2 > max_ed) max_ed <= ed_p2;
        end
    end

endmodule

// File: tb/tb_approx_mult_err_engine.sv
// Directed bench: N=4 engines (combinational and 2-cycle DUT) and an N=16 engine in random mode.
module tb_approx_mult_err_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // N=4, DUT_LAT=0, selectable DUT behaviour
    logic        s4_start = 0, s4_abort = 0, s4_mode = 0;
    logic [7:0]  s4_seed = 8'h5A;
    logic [8:0]  s4_num = 0;
    logic [3:0]  s4_a, s4_b;
    logic [7:0]  s4_y;
    logic        s4_busy, s4_done;
    logic [8:0]  s4_vec, s4_err;
    logic [15:0] s4_sae;
    logic [7:0]  s4_max;
    int          sel4 = 0;

    always_comb begin
        s4_y = {4'b0, s4_a} * {4'b0, s4_b};
        if (sel4 == 1) s4_y = 8'd0;
        else if (sel4 == 2 && s4_a == 4'hF && s4_b == 4'hF) s4_y = 8'd228;
    end

    approx_mult_err_engine #(.N(4), .DUT_LAT(0), .LFSR_TAPS(8'hB8)) u4 (
        .clk(clk), .rst(rst), .start(s4_start), .abort(s4_abort), .mode(s4_mode),
        .seed(s4_seed), .num_samples(s4_num), .dut_a(s4_a), .dut_b(s4_b), .dut_y(s4_y),
        .busy(s4_busy), .done(s4_done), .vec_count(s4_vec), .err_count(s4_err),
        .sae(s4_sae), .max_ed(s4_max));

    // N=4, DUT_LAT=2, two-stage registered exact DUT
    logic        l_start = 0;
    logic [3:0]  l_a, l_b;
    logic [7:0]  l_y1, l_y;
    logic        l_busy, l_done;
    logic [8:0]  l_vec, l_err;
    logic [15:0] l_sae;
    logic [7:0]  l_max;

    always_ff @(posedge clk) begin
        l_y1 <= {4'b0, l_a} * {4'b0, l_b};
        l_y  <= l_y1;
    end

    approx_mult_err_engine #(.N(4), .DUT_LAT(2), .LFSR_TAPS(8'hB8)) u4l2 (
        .clk(clk), .rst(rst), .start(l_start), .abort(1'b0), .mode(1'b0),
        .seed(8'h00), .num_samples(9'd0), .dut_a(l_a), .dut_b(l_b), .dut_y(l_y),
        .busy(l_busy), .done(l_done), .vec_count(l_vec), .err_count(l_err),
        .sae(l_sae), .max_ed(l_max));

    // N=16 random mode, zero DUT
    logic        c_start = 0;
    logic [31:0] c_seed = 0;
    logic [32:0] c_num = 0;
    logic [15:0] c_a, c_b;
    logic        c_busy, c_done;
    logic [32:0] c_vec, c_err;
    logic [63:0] c_sae;
    logic [31:0] c_max;

    approx_mult_err_engine #(.N(16), .DUT_LAT(0)) u16 (
        .clk(clk), .rst(rst), .start(c_start), .abort(1'b0), .mode(1'b1),
        .seed(c_seed), .num_samples(c_num), .dut_a(c_a), .dut_b(c_b), .dut_y(32'd0),
        .busy(c_busy), .done(c_done), .vec_count(c_vec), .err_count(c_err),
        .sae(c_sae), .max_ed(c_max));

    // Pulse start, optionally pulse it again at cycle extra_at, return cycles until done (-1 on timeout)
    task automatic run4(input logic md, input logic [8:0] num, input int extra_at, output int n);
        s4_mode = md; s4_num = num; s4_start = 1'b1; n = -1;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge clk);
            if (i == 1) s4_start = 1'b0;
            if (i == extra_at) s4_start = 1'b1;
            if (i == extra_at + 1) s4_start = 1'b0;
            if (s4_done) begin n = i; break; end
        end
    endtask

    task automatic run_l2(output int n);
        l_start = 1'b1; n = -1;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge clk);
            if (i == 1) l_start = 1'b0;
            if (l_done) begin n = i; break; end
        end
    endtask

    task automatic run16(input logic [31:0] sd, input logic [32:0] num, output int n,
                         output logic [15:0] fa, output logic [15:0] fb);
        c_seed = sd; c_num = num; c_start = 1'b1; n = -1; fa = '0; fb = '0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 1) begin c_start = 1'b0; fa = c_a; fb = c_b; end
            if (c_done) begin n = i; break; end
        end
    endtask

    int          n;
    logic [8:0]  v_frz;
    logic [15:0] fa, fb;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", s4_busy, 0);
        check("rst_done", s4_done, 0);
        check("rst_ops", {s4_a, s4_b}, 0);
        check("rst_metrics", {s4_vec, s4_err, s4_sae, s4_max}, 0);

        sel4 = 0;
        run4(1'b0, 9'd0, 0, n);
        check("exact_latency", n, 259);
        check("exact_vec", s4_vec, 256);
        check("exact_err", s4_err, 0);
        check("exact_sae", s4_sae, 0);
        check("exact_max", s4_max, 0);
        check("exact_busy", s4_busy, 0);

        sel4 = 1;
        run4(1'b0, 9'd0, 0, n);
        check("zero_vec", s4_vec, 256);
        check("zero_err", s4_err, 225);
        check("zero_sae", s4_sae, 14400);
        check("zero_max", s4_max, 225);

        run4(1'b1, 9'd0, 0, n);
        check("num0_latency", n, 1);
        check("num0_metrics", {s4_vec, s4_err, s4_sae, s4_max}, 0);

        sel4 = 2;
        run4(1'b0, 9'd0, 0, n);
        check("over_err", s4_err, 1);
        check("over_sae", s4_sae, 3);
        check("over_max", s4_max, 3);

        sel4 = 1;
        s4_mode = 1'b0; s4_start = 1'b1;
        @(negedge clk);
        s4_start = 1'b0;
        repeat (49) @(negedge clk);
        s4_abort = 1'b1;
        @(negedge clk);
        s4_abort = 1'b0;
        check("abort_busy", s4_busy, 0);
        check("abort_done", s4_done, 0);
        check("abort_vec_le50", (s4_vec <= 9'd50 && s4_vec != 9'd0), 1);
        v_frz = s4_vec;
        repeat (5) @(negedge clk);
        check("abort_frozen", s4_vec, v_frz);
        check("abort_done_later", s4_done, 0);
        sel4 = 0;
        run4(1'b0, 9'd0, 0, n);
        check("post_abort_latency", n, 259);
        check("post_abort_vec", s4_vec, 256);

        sel4 = 1;
        run4(1'b0, 9'd0, 10, n);
        check("filter_latency", n, 259);
        check("filter_vec", s4_vec, 256);
        check("filter_err", s4_err, 225);

        sel4 = 0;
        run4(1'b1, 9'd5, 0, n);
        check("rand5_latency", n, 8);
        check("rand5_vec", s4_vec, 5);
        check("rand5_err", s4_err, 0);

        run_l2(n);
        check("lat2_latency", n, 261);
        check("lat2_vec", l_vec, 256);
        check("lat2_err", l_err, 0);
        check("lat2_sae", l_sae, 0);

        run16(32'h0000_0305, 33'd1, n, fa, fb);
        check("r16_first_a", fa, 16'h0000);
        check("r16_first_b", fb, 16'h0305);
        check("r16_latency", n, 4);
        check("r16_vec", c_vec, 1);
        check("r16_err", c_err, 0);
        check("r16_sae", c_sae, 0);

        run16(32'h0, 33'd1, n, fa, fb);
        check("r16_seed0_a", fa, 16'hFFFF);
        check("r16_seed0_b", fb, 16'hFFFF);
        check("r16_seed0_err", c_err, 1);
        check("r16_seed0_sae", c_sae, 64'hFFFE_0001);

        sel4 = 1;
        s4_mode = 1'b0; s4_start = 1'b1;
        @(negedge clk);
        s4_start = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", s4_busy, 0);
        check("midrst_ops", {s4_a, s4_b}, 0);
        check("midrst_metrics", {s4_vec, s4_err, s4_sae, s4_max}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_no_accum", s4_vec, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/approx_mult_err_engine.md
# approx_mult_err_engine

Hardware error-characterisation engine for N×N approximate multipliers, replacing simulation-only sweeps whose exhaustive runs take days at 16 bits. It generates operand pairs, drives an external approximate multiplier under test (DUT) and compares each DUT product against an internal exact product. It accumulates error count, sum of absolute error distance (SAE) and maximum error distance. It runs either an exhaustive sweep of all 2^(2N) pairs or a seeded LFSR sweep of programmable length, and sits beside the DUT in an FPGA characterisation harness.

## Interface
- N, 16, operand width; the product is 2N bits.
- DUT_LAT, 0, DUT latency in cycles from dut_a/dut_b to a valid dut_y; 0 means a combinational DUT.
- LFSR_TAPS, 32'h80200003, Galois feedback mask for the 2N-bit LFSR; x^32+x^22+x^2+x+1 for N=16.
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; honoured only in IDLE or DONE
- abort  in  1  stops a run
- mode  in  1  0 = exhaustive, 1 = random; sampled at start
- seed  in  2N  LFSR seed; sampled at start; 0 is replaced by all-ones
- num_samples  in  2N+1  random-mode vector count; sampled at start
- dut_a, dut_b  out  N  registered operands to the DUT
- dut_y  in  2N  DUT product
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE
- vec_count  out  2N+1  vectors compared
- err_count  out  2N+1  vectors with dut_y ≠ a*b
- sae  out  4N  sum of |dut_y − a*b|
- max_ed  out  2N  maximum |dut_y − a*b|

## Operation
- FSM states: IDLE → RUN → DRAIN → DONE.
- **IDLE / DONE + start:**
  - Clear all four metric outputs.
  - Latch mode, seed and num_samples.
  - Load the operand source: exhaustive a=0, b=0; random LFSR=seed.
  - Go to RUN, except random mode with num_samples=0, which goes directly to DONE.
- **RUN:** issue one vector per cycle on dut_a/dut_b.
  - Exhaustive: b increments every cycle; when b wraps from 2^N−1 to 0, a increments. After issuing (2^N−1, 2^N−1), go to DRAIN.
  - Random: dut_a = lfsr[2N−1:N], dut_b = lfsr[N−1:0]. The first vector is the seed; the LFSR advances once per issued vector. After num_samples vectors, go to DRAIN.
- **Compare pipeline:** operand copies travel through a DUT_LAT-deep delay line so each dut_y pairs with its own operands.
  - Stage C: register dut_y and exact = a*b (2N bits, unsigned).
  - Stage E: ed = |dut_y − exact|, 2N bits unsigned; computed as the larger minus the smaller.
  - Stage A: vec_count += 1; err_count += (ed≠0); sae += ed; max_ed = max(max_ed, ed).
- **DRAIN:** wait until the in-flight vectors have been accumulated, then go to DONE.
- **DONE:**
  - done stays high and the metrics hold until the next start.
  - start in DONE clears done in the following cycle and launches a new run.
- start is ignored in RUN and DRAIN.
- **abort:**
  - In RUN or DRAIN: go to IDLE next cycle and discard in-flight vectors.
  - Metrics keep their partial values and done is not asserted.
  - abort in IDLE or DONE has no effect.
  - abort together with start: abort wins.
- **Widths:** no counter can overflow.
  - vec_count reaches exactly 2^(2N) in exhaustive mode.
  - sae < 2^(4N).

## Timing
- **Reset:**
  - State IDLE.
  - busy=0, done=0.
  - dut_a=0, dut_b=0.
  - All metrics = 0.
  - LFSR = all-ones.
  - Pipeline valid bits cleared.
  - Reset mid-run aborts immediately with no further accumulation.
- **Run start:** start sampled in cycle S.
  - RUN and busy=1 from cycle S+1.
  - The first vector appears on dut_a/dut_b in cycle S+1.
- **Completion:** last vector issued in cycle L.
  - Its contribution is visible on the metrics in cycle L+DUT_LAT+3.
  - done=1 and busy=0 in that same cycle.
- **Throughput:** one vector per clock.
  - Exhaustive: done at S+2^(2N)+DUT_LAT+3.
  - Random: done at S+num_samples+DUT_LAT+3.
- **num_samples=0 (random):** done=1 in cycle S+1 and the metrics read zero.
- **Output stability:** metrics change only during stage-A updates, so they are monotonic within a run.

## Test plan
- **Exact DUT:** N=4, exhaustive, dut_y=dut_a*dut_b → vec_count=256, err_count=0, sae=0, max_ed=0, done exactly 256+DUT_LAT+3 cycles after start. Repeat with DUT_LAT=2 and a 2-stage registered exact DUT.
- **Zero DUT:** N=4, exhaustive, dut_y=0 → vec_count=256, err_count=225, sae=14400, max_ed=225.
- **Overestimating DUT:** N=4, dut_y=a*b+3 when a=b=15, else exact → err_count=1, sae=3, max_ed=3. This checks the absolute-value path.
- **Random mode:**
  - num_samples=1, seed=0x00000305 with N=16, zero DUT → exactly one vector, a=0x0000, b=0x0305, sae=0, err_count=0.
  - seed=0 → first vector a=0xFFFF, b=0xFFFF.
  - num_samples=0 → done at S+1 with all-zero metrics.
- **Abort:** abort 50 cycles into an N=4 exhaustive run → IDLE next cycle, done stays 0, vec_count ≤ 50 and frozen. A following start produces the full 256-vector result.
- **Reset and start filtering:**
  - rst asserted mid-run → all outputs return to their reset values in the next cycle.
  - start pulses during RUN are ignored, and vec_count still ends at 256.
